// File: rtl/pit_pkg.sv
// Shared encodings for the 8254 host interface: command fields, FSM states, bus-byte builders.
// Pure declarations and functions; no timing or backpressure of its own.
package pit_pkg;

    typedef enum logic [1:0] {
        OP_WRITE_COUNT = 2'b00,
        OP_READ_COUNT  = 2'b01,
        OP_READ_STATUS = 2'b10,
        OP_RSVD        = 2'b11
    } pit_op_e;

    typedef enum logic [1:0] {
        RW_NONE    = 2'b00,
        RW_LSB     = 2'b01,
        RW_MSB     = 2'b10,
        RW_LSB_MSB = 2'b11
    } pit_rw_e;

    localparam logic [1:0] PIT_CTRL_ADDR = 2'b11;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_STROBE,
        BUS_HOLD
    } pit_bus_state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_BUS,
        HS_RESP
    } pit_host_state_e;

    typedef struct packed {
        pit_op_e     op;
        logic [1:0]  sel;
        pit_rw_e     rw;
        logic [2:0]  mode;
        logic        bcd;
        logic [15:0] count;
    } pit_cmd_t;

    // hi selects the MSB lane: count byte for writes, rsp_data half for reads
    typedef struct packed {
        logic       is_read;
        logic       hi;
        logic [1:0] addr;
        logic [7:0] wdata;
    } pit_byte_t;

    function automatic logic [7:0] pit_ctrl_byte(input pit_cmd_t c);
        logic [7:0] b;
        case (c.op)
            OP_WRITE_COUNT: b = {c.sel, c.rw, c.mode, c.bcd};
            OP_READ_COUNT:  b = {c.sel, 6'b000000};
            default:        b = {2'b11, 1'b1, 1'b0, c.sel == 2'd2, c.sel == 2'd1, c.sel == 2'd0, 1'b0};
        endcase
        return b;
    endfunction

    function automatic logic [1:0] pit_num_bytes(input pit_cmd_t c);
        if (c.op == OP_READ_STATUS || c.rw != RW_LSB_MSB)
            return 2'd2;
        return 2'd3;
    endfunction

    function automatic pit_byte_t pit_cmd_byte(input pit_cmd_t c, input logic [1:0] idx);
        pit_byte_t b;
        b         = '0;
        b.hi      = (c.rw == RW_MSB) || (c.rw == RW_LSB_MSB && idx == 2'd2);
        if (idx == 2'd0) begin
            b.addr  = PIT_CTRL_ADDR;
            b.wdata = pit_ctrl_byte(c);
        end else begin
            b.addr    = c.sel;
            b.is_read = (c.op != OP_WRITE_COUNT);
            if (c.op == OP_WRITE_COUNT)
                b.wdata = b.hi ? c.count[15:8] : c.count[7:0];
        end
        return b;
    endfunction

endpackage

// File: rtl/pit_bus_cycle.sv
// Single-byte 8254 bus cycle: SETUP -> STROBE -> HOLD, SETUP_CYC+STROBE_CYC+HOLD_CYC cycles per byte.
// A start on the final HOLD cycle chains the next byte with CS kept low; done pulses on that cycle.
module pit_bus_cycle
    import pit_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic       is_read_i,
    input  logic [1:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       cs_n_o,
    output logic       wr_n_o,
    output logic       rd_n_o,
    output logic [1:0] a_o,
    output logic [7:0] dout_o,
    output logic       doe_o,
    input  logic [7:0] din_i
);

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    pit_bus_state_e state_q;
    logic [3:0]     cnt_q;
    logic           read_q;
    logic [7:0]     rdata_q;
    logic           cs_n_q, wr_n_q, rd_n_q, doe_q;
    logic [1:0]     a_q;
    logic [7:0]     dout_q;

    assign done_o  = (state_q == BUS_HOLD) && (cnt_q == 4'd0);
    assign rdata_o = rdata_q;
    assign cs_n_o  = cs_n_q;
    assign wr_n_o  = wr_n_q;
    assign rd_n_o  = rd_n_q;
    assign a_o     = a_q;
    assign dout_o  = dout_q;
    assign doe_o   = doe_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= BUS_IDLE;
            cnt_q   <= 4'd0;
            read_q  <= 1'b0;
            rdata_q <= 8'h00;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            a_q     <= 2'b00;
            dout_q  <= 8'h00;
            doe_q   <= 1'b0;
        end else if (start_i && (state_q == BUS_IDLE || done_o)) begin
            state_q <= BUS_SETUP;
            cnt_q   <= SETUP_LD;
            read_q  <= is_read_i;
            cs_n_q  <= 1'b0;
            a_q     <= addr_i;
            dout_q  <= wdata_i;
            doe_q   <= !is_read_i;
        end else begin
            case (state_q)
                BUS_SETUP: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= BUS_STROBE;
                        cnt_q   <= STROBE_LD;
                        wr_n_q  <= read_q;
                        rd_n_q  <= !read_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                BUS_STROBE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= BUS_HOLD;
                        cnt_q   <= HOLD_LD;
                        wr_n_q  <= 1'b1;
                        rd_n_q  <= 1'b1;
                        if (read_q)
                            rdata_q <= din_i;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                BUS_HOLD: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= BUS_IDLE;
                        cs_n_q  <= 1'b1;
                        doe_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= BUS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pit_host_interface.sv
// 8254 host command expander: one command -> 2..3 bus bytes; response 1+N*(SETUP+STROBE+HOLD) cycles after accept.
// One command in flight; cmd_ready only in IDLE, response held until rsp_ready. PIT_READBACK_EN enables READ_STATUS.
module pit_host_interface
    import pit_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic        global_CLK,
    input  logic        RST_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_sel,
    input  logic [1:0]  cmd_rw,
    input  logic [2:0]  cmd_mode,
    input  logic        cmd_bcd,
    input  logic [15:0] cmd_count,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [7:0]  rsp_status,
    output logic        rsp_err,
    output logic        CS,
    output logic        WR,
    output logic        RD,
    output logic [1:0]  A,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in
);

`ifdef PIT_READBACK_EN
    localparam bit READBACK_EN = 1'b1;
`else
    localparam bit READBACK_EN = 1'b0;
`endif

    function automatic logic is_illegal(input pit_cmd_t c);
        return (c.sel == 2'd3) || (c.op == OP_RSVD) ||
               (c.op != OP_READ_STATUS && c.rw == RW_NONE) ||
               (c.op == OP_READ_STATUS && !READBACK_EN);
    endfunction

    pit_host_state_e state_q;
    pit_cmd_t        cmd_q;
    logic [1:0]      idx_q;
    logic [15:0]     rsp_data_q;
    logic            rsp_err_q;

    pit_cmd_t  cmd_in;
    pit_byte_t cur_byte, next_byte;
    logic      accept, illegal_in, last_byte, bus_done, bus_start;
    logic [7:0] bus_rdata;

    always_comb begin
        cmd_in       = '0;
        cmd_in.op    = pit_op_e'(cmd_op);
        cmd_in.sel   = cmd_sel;
        cmd_in.rw    = pit_rw_e'(cmd_rw);
        cmd_in.mode  = cmd_mode;
        cmd_in.bcd   = cmd_bcd;
        cmd_in.count = cmd_count;
    end

    assign accept     = (state_q == HS_IDLE) && cmd_valid;
    assign illegal_in = is_illegal(cmd_in);
    assign last_byte  = (idx_q == pit_num_bytes(cmd_q) - 2'd1);
    assign cur_byte   = pit_cmd_byte(cmd_q, idx_q);
    assign next_byte  = accept ? pit_cmd_byte(cmd_in, 2'd0) : pit_cmd_byte(cmd_q, idx_q + 2'd1);
    assign bus_start  = (accept && !illegal_in) || (state_q == HS_BUS && bus_done && !last_byte);

    assign cmd_ready = (state_q == HS_IDLE);
    assign rsp_valid = (state_q == HS_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    pit_bus_cycle #(
        .SETUP_CYC (SETUP_CYC),
        .STROBE_CYC(STROBE_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_bus (
        .clk_i    (global_CLK),
        .rst_n_i  (RST_n),
        .start_i  (bus_start),
        .is_read_i(next_byte.is_read),
        .addr_i   (next_byte.addr),
        .wdata_i  (next_byte.wdata),
        .done_o   (bus_done),
        .rdata_o  (bus_rdata),
        .cs_n_o   (CS),
        .wr_n_o   (WR),
        .rd_n_o   (RD),
        .a_o      (A),
        .dout_o   (data_out),
        .doe_o    (data_oe),
        .din_i    (data_in)
    );

    always_ff @(posedge global_CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= HS_IDLE;
            cmd_q      <= '0;
            idx_q      <= 2'd0;
            rsp_data_q <= 16'h0000;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                HS_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q      <= cmd_in;
                        idx_q      <= 2'd0;
                        rsp_data_q <= 16'h0000;
                        rsp_err_q  <= illegal_in;
                        state_q    <= illegal_in ? HS_RESP : HS_BUS;
                    end
                end
                HS_BUS: begin
                    if (bus_done) begin
                        if (cur_byte.is_read && cmd_q.op == OP_READ_COUNT) begin
                            if (cur_byte.hi)
                                rsp_data_q[15:8] <= bus_rdata;
                            else
                                rsp_data_q[7:0] <= bus_rdata;
                        end
                        if (last_byte)
                            state_q <= HS_RESP;
                        else
                            idx_q <= idx_q + 2'd1;
                    end
                end
                HS_RESP: begin
                    if (rsp_ready)
                        state_q <= HS_IDLE;
                end
                default: state_q <= HS_IDLE;
            endcase
        end
    end

`ifdef PIT_READBACK_EN
    logic [7:0] status_q;

    always_ff @(posedge global_CLK or negedge RST_n) begin
        if (!RST_n)
            status_q <= 8'h00;
        else if (accept)
            status_q <= 8'h00;
        else if (state_q == HS_BUS && bus_done && cur_byte.is_read && cmd_q.op == OP_READ_STATUS)
            status_q <= bus_rdata;
    end

    assign rsp_status = status_q;
`else
    assign rsp_status = 8'h00;
`endif

endmodule

// File: tb/tb_pit_host_interface.sv
// Bench for pit_host_interface: directed cases plus random commands checked against a
// transaction-level model of the expected bus bytes, latency and response.
module tb_pit_host_interface;

    localparam int S = 1, ST = 2, H = 1;
    localparam int BYTE_CYC = S + ST + H;
`ifdef PIT_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RST_n;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = '0, cmd_sel = '0, cmd_rw = '0;
    logic [2:0]  cmd_mode = '0;
    logic        cmd_bcd = 1'b0;
    logic [15:0] cmd_count = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [15:0] rsp_data;
    logic [7:0]  rsp_status;
    logic        CS, WR, RD, data_oe;
    logic [1:0]  A;
    logic [7:0]  data_out, data_in;

    pit_host_interface #(.SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H)) dut (
        .global_CLK(clk), .RST_n(RST_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
        .cmd_rw(cmd_rw), .cmd_mode(cmd_mode), .cmd_bcd(cmd_bcd), .cmd_count(cmd_count),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .rsp_err(rsp_err),
        .CS(CS), .WR(WR), .RD(RD), .A(A), .data_out(data_out), .data_oe(data_oe),
        .data_in(data_in)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic       rd;
        logic [1:0] a;
        logic [7:0] d;
    } txn_t;

    txn_t       obs_q[$], exp_q[$];
    txn_t       mon_t;
    logic [7:0] rd_vals[4];
    int         rd_idx = 0;
    bit         mon_en = 1'b1, cs_seen = 1'b0;
    int         wr_run = 0, rd_run = 0;

    assign data_in = rd_vals[rd_idx[1:0]];

    // Bus monitor: one transaction per completed strobe, plus strobe-level protocol checks
    always @(negedge clk) begin
        if (!RST_n) begin
            wr_run = 0;
            rd_run = 0;
        end else begin
            if (!CS) cs_seen = 1'b1;
            if (!WR) wr_run++;
            if (!RD) rd_run++;
            if (mon_en && (!WR || !RD)) begin
                chk("cs_low_during_strobe", 32'(CS), 32'(0));
                chk("oe_during_strobe", 32'(data_oe), 32'(!WR));
            end
            if (WR && wr_run > 0) begin
                if (mon_en) begin
                    mon_t = {1'b0, A, data_out};
                    obs_q.push_back(mon_t);
                    chk("wr_strobe_width", 32'(wr_run), 32'(ST));
                end
                wr_run = 0;
            end
            if (RD && rd_run > 0) begin
                if (mon_en) begin
                    mon_t = {1'b1, A, data_in};
                    obs_q.push_back(mon_t);
                    chk("rd_strobe_width", 32'(rd_run), 32'(ST));
                end
                rd_run = 0;
                rd_idx++;
            end
        end
    end

    logic        exp_err;
    logic [15:0] exp_data, last_data;
    logic [7:0]  exp_status, last_status;
    logic        last_err;

    task automatic push_exp(input logic rd, input logic [1:0] a, input logic [7:0] d);
        txn_t t;
        t = {rd, a, d};
        exp_q.push_back(t);
    endtask

    task automatic model(input logic [1:0] op, input logic [1:0] sel, input logic [1:0] rw,
                         input logic [2:0] mode, input logic bcd, input logic [15:0] cnt);
        int k;
        logic [7:0] lo, hi;
        k = 0; lo = 8'h00; hi = 8'h00;
        exp_q.delete();
        exp_err = 1'b0; exp_data = 16'h0000; exp_status = 8'h00;
        if (sel == 2'd3 || op == 2'd3 || (op != 2'd2 && rw == 2'd0) || (op == 2'd2 && !RB)) begin
            exp_err = 1'b1;
            return;
        end
        case (op)
            2'd0: begin
                push_exp(1'b0, 2'd3, {sel, rw, mode, bcd});
                if (rw[0]) push_exp(1'b0, sel, cnt[7:0]);
                if (rw[1]) push_exp(1'b0, sel, cnt[15:8]);
            end
            2'd1: begin
                push_exp(1'b0, 2'd3, {sel, 6'b000000});
                if (rw[0]) begin lo = rd_vals[k]; k++; push_exp(1'b1, sel, lo); end
                if (rw[1]) begin hi = rd_vals[k]; k++; push_exp(1'b1, sel, hi); end
                exp_data = {hi, lo};
            end
            default: begin
                push_exp(1'b0, 2'd3, 8'hE0 | (8'h02 << sel));
                push_exp(1'b1, sel, rd_vals[0]);
                exp_status = rd_vals[0];
            end
        endcase
    endtask

    // Issues one command from a negedge and returns at a negedge after the response handshake
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] sel, input logic [1:0] rw,
                           input logic [2:0] mode, input logic bcd, input logic [15:0] cnt,
                           input int hold, input bit offer);
        int lat, n;
        model(op, sel, rw, mode, bcd, cnt);
        obs_q.delete();
        rd_idx = 0;
        cs_seen = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_rw = rw;
        cmd_mode = mode; cmd_bcd = bcd; cmd_count = cnt;
        lat = 0;
        while (!cmd_ready && lat < 50) begin @(negedge clk); lat++; end
        chk("cmd_ready_before_accept", 32'(cmd_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_sel = 2'($urandom); cmd_rw = 2'($urandom);
        cmd_count = 16'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        chk("rsp_latency", 32'(lat), exp_err ? 32'(1) : 32'(1 + exp_q.size() * BYTE_CYC));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_data", 32'(rsp_data), 32'(exp_data));
        chk("rsp_status", 32'(rsp_status), 32'(exp_status));
        chk("bus_byte_count", 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("bus_byte%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
        if (exp_err) chk("no_cs_on_err", 32'(cs_seen), 32'(0));
        chk("cs_high_in_resp", 32'(CS), 32'(1));
        last_data = rsp_data; last_status = rsp_status; last_err = rsp_err;
        if (offer) begin
            cmd_valid = 1'b1; cmd_op = 2'd0; cmd_sel = 2'd0; cmd_rw = 2'd3;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("hold_rsp_data", 32'(rsp_data), 32'(exp_data));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'(0));
        end
        if (hold > 0) chk("hold_no_bus", 32'(obs_q.size()), 32'(exp_q.size()));
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", 32'(rsp_valid), 32'(0));
        chk("cmd_ready_after_hs", 32'(cmd_ready), 32'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) rd_vals[i] = 8'h00;
        RST_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_CS", 32'(CS), 32'(1));
        chk("rst_WR", 32'(WR), 32'(1));
        chk("rst_RD", 32'(RD), 32'(1));
        chk("rst_A", 32'(A), 32'(0));
        chk("rst_data_out", 32'(data_out), 32'(0));
        chk("rst_data_oe", 32'(data_oe), 32'(0));
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_data", 32'(rsp_data), 32'(0));
        chk("rst_rsp_status", 32'(rsp_status), 32'(0));
        chk("rst_rsp_err", 32'(rsp_err), 32'(0));
        RST_n = 1'b1;
        @(negedge clk);

        run_cmd(2'd0, 2'd1, 2'd3, 3'd2, 1'b0, 16'h1234, 0, 1'b0);
        chk("wc_ctrl_word", 32'(obs_q[0]), 32'({1'b0, 2'b11, 8'h74}));
        chk("wc_lsb", 32'(obs_q[1]), 32'({1'b0, 2'b01, 8'h34}));
        chk("wc_msb", 32'(obs_q[2]), 32'({1'b0, 2'b01, 8'h12}));

        rd_vals[0] = 8'hCD; rd_vals[1] = 8'hAB;
        run_cmd(2'd1, 2'd0, 2'd3, 3'd0, 1'b0, 16'h0000, 0, 1'b0);
        chk("rc_latch_word", 32'(obs_q[0]), 32'({1'b0, 2'b11, 8'h00}));
        chk("rc_data_abcd", 32'(last_data), 32'(16'hABCD));

        run_cmd(2'd1, 2'd0, 2'd2, 3'd0, 1'b0, 16'h0000, 0, 1'b0);
        chk("rc_msb_only", 32'(last_data), 32'(16'hCD00));

        run_cmd(2'd0, 2'd3, 2'd3, 3'd1, 1'b0, 16'h5555, 0, 1'b0);
        chk("sel3_err", 32'(last_err), 32'(1));

        rd_vals[0] = 8'h96;
        run_cmd(2'd2, 2'd2, 2'd0, 3'd0, 1'b0, 16'h0000, 0, 1'b0);
`ifdef PIT_READBACK_EN
        chk("rs_readback_word", 32'(obs_q[0]), 32'({1'b0, 2'b11, 8'hE8}));
        chk("rs_status", 32'(last_status), 32'(8'h96));
`else
        chk("rs_disabled_err", 32'(last_err), 32'(1));
        chk("rs_disabled_no_bus", 32'(obs_q.size()), 32'(0));
`endif

        // Reset during STROBE of the second byte of a 3-byte write
        mon_en = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_sel = 2'd0; cmd_rw = 2'd3; cmd_count = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid_wr_low", 32'(WR), 32'(0));
        #1 RST_n = 1'b0;
        #1;
        chk("rst_mid_WR", 32'(WR), 32'(1));
        chk("rst_mid_CS", 32'(CS), 32'(1));
        chk("rst_mid_oe", 32'(data_oe), 32'(0));
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'(0));
        RST_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));
            chk("post_rst_CS", 32'(CS), 32'(1));
        end
        mon_en = 1'b1;

        run_cmd(2'd0, 2'd2, 2'd1, 3'd3, 1'b1, 16'h0099, 20, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] op, sel, rw;
            for (int i = 0; i < 4; i++) rd_vals[i] = 8'($urandom);
            op  = 2'($urandom_range(0, 3));
            sel = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rw  = 2'($urandom_range(0, 3));
            run_cmd(op, sel, rw, 3'($urandom), 1'($urandom), 16'($urandom),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
